// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the pipelined carry adder.
// The optional signed-overflow output is enabled by the PIPE_ADDER_OVF_EN macro.
package pipe_adder_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    // Elaboration guard: the carry chain must split into equal, non-empty chunks.
    function automatic bit width_ok(input int width, input int stages);
        return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
    endfunction

    // One full-adder cell: returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/pipelined_carry_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
// Also exposes the carry into the MSB so the caller can derive signed overflow.
module chunk_adder
    import pipe_adder_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o,
    output logic         cmsb_o
);

    logic carry;

    always_comb begin
        carry  = c_i;
        cmsb_o = 1'b0;
        s_o    = '0;
        for (int i = 0; i < W; i++) begin
            // The last value captured here is the carry entering bit W-1.
            cmsb_o = carry;
            {carry, s_o[i]} = full_add(a_i[i], b_i[i], carry);
        end
        c_o = carry;
    end

endmodule

// File: rtl/pipelined_carry_adder.sv
// WIDTH-bit adder with the carry chain split over STAGES registered chunks and a
// valid/ready handshake with full backpressure. Macro PIPE_ADDER_OVF_EN adds port ovf.
module pipelined_carry_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    if (!width_ok(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_carry_adder: WIDTH must be a positive multiple of STAGES");
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int IW = WIDTH - k * CHUNK;   // operand bits not yet added
        localparam int SW = (k + 1) * CHUNK;     // sum bits completed after this stage

        logic             v_q;
        logic             v_in;
        logic             ld;
        logic             adv;
        logic [IW-1:0]    src_a;
        logic [IW-1:0]    src_b;
        logic             src_c;
        logic [CHUNK-1:0] cs;
        logic             co;
        logic             cm;
        logic [SW-1:0]    sum_d;
        logic [SW-1:0]    sum_q;
        logic             c_q;
        logic             unused_cm;

        assign unused_cm = cm;

        if (k == 0) begin : g_head
            assign src_a = a;
            assign src_b = b;
            assign src_c = cin;
            assign v_in  = in_valid;
            assign sum_d = cs;
        end else begin : g_link
            assign src_a = g_st[k-1].g_skew.a_q;
            assign src_b = g_st[k-1].g_skew.b_q;
            assign src_c = g_st[k-1].c_q;
            assign v_in  = g_st[k-1].v_q;
            assign sum_d = {cs, g_st[k-1].sum_q};
        end

        // A stage may load when empty or when its current contents move on.
        if (k == STAGES - 1) begin : g_adv_out
            assign adv = out_ready;
        end else begin : g_adv_next
            assign adv = g_st[k+1].ld;
        end
        assign ld = !v_q || adv;

        chunk_adder #(.W(CHUNK)) u_chunk (
            .a_i    (src_a[CHUNK-1:0]),
            .b_i    (src_b[CHUNK-1:0]),
            .c_i    (src_c),
            .s_o    (cs),
            .c_o    (co),
            .cmsb_o (cm)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
            end else if (ld) begin
                v_q <= v_in;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [IW-CHUNK-1:0] a_q;
            logic [IW-CHUNK-1:0] b_q;

            always_ff @(posedge clk) begin
                if (ld && v_in) begin
                    a_q   <= src_a[IW-1:CHUNK];
                    b_q   <= src_b[IW-1:CHUNK];
                    sum_q <= sum_d;
                    c_q   <= co;
                end
            end
        end else begin : g_tail
`ifdef PIPE_ADDER_OVF_EN
            logic ovf_q;
`endif
            // Output registers are cleared so a reset presents a zero result.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum_q <= '0;
                    c_q   <= 1'b0;
`ifdef PIPE_ADDER_OVF_EN
                    ovf_q <= 1'b0;
`endif
                end else if (ld && v_in) begin
                    sum_q <= sum_d;
                    c_q   <= co;
`ifdef PIPE_ADDER_OVF_EN
                    ovf_q <= cm ^ co;
`endif
                end
            end
        end
    end

    assign in_ready  = g_st[0].ld && !rst;
    assign out_valid = g_st[STAGES-1].v_q;
    assign sum       = g_st[STAGES-1].sum_q;
    assign cout      = g_st[STAGES-1].c_q;
`ifdef PIPE_ADDER_OVF_EN
    assign ovf       = g_st[STAGES-1].g_tail.ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Self-checking bench for pipelined_carry_adder (16/4 main instance, 4/2 small instance).
module tb_pipelined_carry_adder;

    localparam int W  = 16;
    localparam int S  = 4;
    localparam int SW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [W-1:0] a, b, sum;
    logic          s_in_valid, s_in_ready, s_cin, s_out_valid, s_out_ready, s_cout;
    logic [SW-1:0] s_a, s_b, s_sum;
`ifdef PIPE_ADDER_OVF_EN
    logic ovf, s_ovf;
`endif

    pipelined_carry_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    pipelined_carry_adder #(.WIDTH(SW), .STAGES(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .cin(s_cin), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .sum(s_sum), .cout(s_cout)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(s_ovf)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    logic [W:0] expq[$];

    // Reference: plain (WIDTH+1)-bit arithmetic, {cout, sum}.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic c, input logic r);
        @(posedge clk);
        #1;
        in_valid = v; a = av; b = bv; cin = c; out_ready = r;
        #1;
    endtask

    task automatic s_drive(input logic v, input logic [SW-1:0] av, input logic [SW-1:0] bv,
                           input logic c, input logic r);
        @(posedge clk);
        #1;
        s_in_valid = v; s_a = av; s_b = bv; s_cin = c; s_out_ready = r;
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_vec++;
        if ({out_valid, in_ready, cout, sum} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got ov=%b ir=%b co=%b sum=%h, want all 0", out_valid, in_ready, cout, sum);
        end
        n_vec++;
        if ({s_out_valid, s_in_ready, s_cout, s_sum} !== '0) begin
            n_err++;
            $display("FAIL reset_state_small: got ov=%b ir=%b co=%b sum=%h, want all 0", s_out_valid, s_in_ready, s_cout, s_sum);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b/%b, want 1/1", in_ready, s_in_ready);
        end
    endtask

    task automatic test_small_directed();
        s_drive(1'b1, 4'b0101, 4'b0101, 1'b0, 1'b1);
        s_drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
        n_vec++;
        if (s_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL small_early_valid: got %b, want 0", s_out_valid);
        end
        s_drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
        n_vec++;
        if ({s_out_valid, s_cout, s_sum} !== {1'b1, 1'b0, 4'b1010}) begin
            n_err++;
            $display("FAIL small_0101_0101: got v=%b co=%b sum=%b, want v=1 co=0 sum=1010", s_out_valid, s_cout, s_sum);
        end
        s_drive(1'b1, 4'b1111, 4'b0001, 1'b1, 1'b1);
        s_drive(1'b1, 4'b1000, 4'b1000, 1'b0, 1'b1);
        s_drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
        n_vec++;
        if ({s_out_valid, s_cout, s_sum} !== {1'b1, 1'b1, 4'b0001}) begin
            n_err++;
            $display("FAIL small_b2b_first: got v=%b co=%b sum=%b, want v=1 co=1 sum=0001", s_out_valid, s_cout, s_sum);
        end
        s_drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
        n_vec++;
        if ({s_out_valid, s_cout, s_sum} !== {1'b1, 1'b1, 4'b0000}) begin
            n_err++;
            $display("FAIL small_b2b_second: got v=%b co=%b sum=%b, want v=1 co=1 sum=0000", s_out_valid, s_cout, s_sum);
        end
        s_drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
        n_vec++;
        if (s_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL small_idle_after: got %b, want 0", s_out_valid);
        end
    endtask

    task automatic test_latency();
        drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        for (int i = 1; i <= S; i++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1);
            n_vec++;
            if (i < S && out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL latency_early cycle %0d: got out_valid=%b, want 0", i, out_valid);
            end else if (i == S && {out_valid, cout, sum} !== {1'b1, 1'b1, 16'h0000}) begin
                n_err++;
                $display("FAIL latency_carry_chain: got v=%b co=%b sum=%h, want v=1 co=1 sum=0000", out_valid, cout, sum);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] av, bv;
        logic         c;
        int           acc = 0;
        for (int i = 0; i < S + 2; i++) begin
            av = W'($urandom); bv = W'($urandom); c = 1'($urandom);
            drive(1'b1, av, bv, c, 1'b0);
            n_vec++;
            if (in_ready !== (expq.size() < S)) begin
                n_err++;
                $display("FAIL bp_in_ready cycle %0d: got %b, want %b", i, in_ready, expq.size() < S);
            end
            if (in_ready === 1'b1) begin
                expq.push_back(model(av, bv, c));
                acc++;
            end
        end
        n_vec++;
        if (acc != S) begin
            n_err++;
            $display("FAIL bp_accept_count: got %0d, want %0d", acc, S);
        end
        for (int i = 0; i < S; i++) begin
            logic [W:0] e;
            drive(1'b0, '0, '0, 1'b0, 1'b1);
            if (i == 0) begin
                n_vec++;
                if (in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL bp_ready_on_release: got %b, want 1", in_ready);
                end
            end
            e = (expq.size() > 0) ? expq.pop_front() : '0;
            n_vec++;
            if ({out_valid, cout, sum} !== {1'b1, e}) begin
                n_err++;
                $display("FAIL bp_drain %0d: got v=%b co=%b sum=%h, want v=1 co=%b sum=%h", i, out_valid, cout, sum, e[W], e[W-1:0]);
            end
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_empty_after: got out_valid=%b, want 0", out_valid);
        end
        expq.delete();
    endtask

    task automatic test_random_stream(input int n, input int pv, input int pr);
        for (int i = 0; i < n; i++) begin
            logic         v, r, c;
            logic [W-1:0] av, bv;
            logic [W:0]   e;
            v = ($urandom_range(0, 99) < pv);
            r = ($urandom_range(0, 99) < pr);
            av = W'($urandom); bv = W'($urandom); c = 1'($urandom);
            drive(v, av, bv, c, r);
            n_vec++;
            if (in_ready !== ((expq.size() < S) || r)) begin
                n_err++;
                $display("FAIL rnd_in_ready cycle %0d: got %b, want %b", i, in_ready, (expq.size() < S) || r);
            end
            if ((expq.size() == 0 && out_valid !== 1'b0) || (expq.size() == S && out_valid !== 1'b1)) begin
                n_err++;
                $display("FAIL rnd_out_valid cycle %0d: got %b with %0d in flight", i, out_valid, expq.size());
            end
            if (out_valid === 1'b1 && r && expq.size() > 0) begin
                e = expq.pop_front();
                n_vec++;
                if ({cout, sum} !== e) begin
                    n_err++;
                    $display("FAIL rnd_result cycle %0d: got co=%b sum=%h, want co=%b sum=%h", i, cout, sum, e[W], e[W-1:0]);
                end
            end
            if (v && in_ready === 1'b1) expq.push_back(model(av, bv, c));
        end
        for (int i = 0; i < 60 && expq.size() > 0; i++) begin
            logic [W:0] e;
            drive(1'b0, '0, '0, 1'b0, 1'b1);
            if (out_valid === 1'b1) begin
                e = expq.pop_front();
                n_vec++;
                if ({cout, sum} !== e) begin
                    n_err++;
                    $display("FAIL rnd_drain: got co=%b sum=%h, want co=%b sum=%h", cout, sum, e[W], e[W-1:0]);
                end
            end
        end
        n_vec++;
        if (expq.size() != 0) begin
            n_err++;
            $display("FAIL rnd_drain_timeout: got %0d results outstanding, want 0", expq.size());
        end
        expq.delete();
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) drive(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({out_valid, in_ready, cout, sum} !== '0) begin
            n_err++;
            $display("FAIL midreset_async: got ov=%b ir=%b co=%b sum=%h, want all 0", out_valid, in_ready, cout, sum);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_release_ready: got %b, want 1", in_ready);
        end
        for (int i = 0; i < S + 2; i++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1);
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL midreset_stale cycle %0d: got out_valid=%b, want 0", i, out_valid);
            end
        end
    endtask

`ifdef PIPE_ADDER_OVF_EN
    task automatic test_ovf();
        drive(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        for (int i = 0; i < S - 1; i++) drive(1'b0, '0, '0, 1'b0, 1'b1);
        n_vec++;
        if ({out_valid, ovf, cout} !== 3'b110) begin
            n_err++;
            $display("FAIL ovf_7fff: got v=%b ovf=%b co=%b, want v=1 ovf=1 co=0", out_valid, ovf, cout);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        n_vec++;
        if ({out_valid, ovf, cout} !== 3'b101) begin
            n_err++;
            $display("FAIL ovf_ffff: got v=%b ovf=%b co=%b, want v=1 ovf=0 co=1", out_valid, ovf, cout);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_out_ready = 1'b0;
        test_reset();
        test_small_directed();
        test_latency();
        test_backpressure();
        test_random_stream(300, 70, 60);
        test_random_stream(200, 95, 95);
        test_random_stream(200, 90, 25);
        test_reset_midstream();
`ifdef PIPE_ADDER_OVF_EN
        test_ovf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
